// File: rtl/demux_rr_scheduler_pkg.sv
// demux_rr_scheduler_pkg: shared channel, mode and FSM definitions for the demux scheduler
package demux_rr_scheduler_pkg;
    localparam int NUM_CH = 4;
    localparam logic [1:0] CH_Y0 = 2'd0;
    localparam logic [1:0] CH_Y1 = 2'd1;
    localparam logic [1:0] CH_Y2 = 2'd2;
    localparam logic [1:0] CH_Y3 = 2'd3;
    localparam logic MODE_RR = 1'b0;
    localparam logic MODE_FIXED = 1'b1;
    typedef enum logic {EMPTY, FULL} state_t;
endpackage

// File: rtl/demux_rr_scheduler_if.sv
// demux_rr_scheduler_if: input stream and demux-side handshake bundle
interface demux_rr_scheduler_if
    import demux_rr_scheduler_pkg::*;
#(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [1:0]        sel;
    logic [NUM_CH-1:0] out_valid;
    logic [NUM_CH-1:0] out_ready;
    logic [DATA_W-1:0] out_data;
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, sel, out_valid, out_data
    );
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, sel, out_valid, out_data
    );
endinterface

// File: rtl/demux_rr_scheduler_sat_counter.sv
// sat_counter: delivery counter that sticks at all-ones, with clear winning over increment
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // clear first, then increment only below the ceiling
    always_comb cnt_d = clr_i ? '0 : (inc_i && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    // counter register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    assign cnt_o = cnt_q;
endmodule

// File: rtl/demux_rr_scheduler.sv
// demux_rr_scheduler: single-entry holding stage steering each word to one of four channels
module demux_rr_scheduler
    import demux_rr_scheduler_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_mode,
    input  logic [1:0]            cfg_sel,
    input  logic                  cnt_clr,
    demux_rr_scheduler_if.slave   bus,
    output logic [CNT_W-1:0]      cnt0,
    output logic [CNT_W-1:0]      cnt1,
    output logic [CNT_W-1:0]      cnt2,
    output logic [CNT_W-1:0]      cnt3
);
    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [1:0]        sel_q, sel_d;
    logic [1:0]        rr_q, rr_d;
    logic              deliver, in_ready, accept;
    logic [1:0]        target;
    logic [CNT_W-1:0]  cnt_w [NUM_CH];
    // handshake: a held word leaves when its own channel is ready, freeing the slot the same cycle
    always_comb begin
        deliver  = state_q == FULL && bus.out_ready[sel_q];
        in_ready = state_q == EMPTY || deliver;
        accept   = bus.in_valid && in_ready;
        target   = cfg_mode == MODE_FIXED ? cfg_sel : rr_q;
    end
    // FSM state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    // FSM next state: only a delivery with no replacement empties the slot
    always_comb
        state_d = state_q == EMPTY ? (accept ? FULL : EMPTY) : (deliver && !accept ? EMPTY : FULL);
    // FSM outputs: one-hot decode of the latched select while holding a word
    always_comb begin
        bus.in_ready  = in_ready;
        bus.out_valid = state_q == FULL ? (NUM_CH)'(1) << sel_q : '0;
        bus.sel       = sel_q;
        bus.out_data  = data_q;
    end
    // datapath next state: word and target latched on accept, pointer advances only in RR mode
    always_comb begin
        data_d = accept ? bus.in_data : data_q;
        sel_d  = accept ? target : sel_q;
        rr_d   = accept && cfg_mode == MODE_RR ? rr_q + 2'd1 : rr_q;
    end
    // datapath registers
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            data_q <= '0;
            sel_q  <= CH_Y0;
            rr_q   <= CH_Y0;
        end else begin
            data_q <= data_d;
            sel_q  <= sel_d;
            rr_q   <= rr_d;
        end
    for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt
        sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc_i (deliver && sel_q == 2'(i)),
            .clr_i (cnt_clr),
            .cnt_o (cnt_w[i])
        );
    end
    assign cnt0 = cnt_w[0];
    assign cnt1 = cnt_w[1];
    assign cnt2 = cnt_w[2];
    assign cnt3 = cnt_w[3];
endmodule

// File: tb/tb_demux_rr_scheduler.sv
// tb_demux_rr_scheduler: table vectors plus scoreboard checks of the demux scheduler
module tb_demux_rr_scheduler;
    import demux_rr_scheduler_pkg::*;
    typedef struct {
        logic [1:0] ch;
        logic [7:0] data;
    } exp_t;
    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [3:0] r;
        logic       m;
        logic [1:0] s;
        logic [3:0] ov;
        logic [7:0] od;
        logic [1:0] osel;
        logic       ir;
    } vec_t;
    logic clk = 0, rst_n = 0, cfg_mode = 0, cnt_clr = 0;
    logic [1:0] cfg_sel = 0;
    logic [15:0] c [4];
    logic [1:0] cs [4];
    exp_t q [$];
    int rr_m, n_chk, n_fail;
    int ecnt [4], ecnt_s [4];
    vec_t tbl [14];
    demux_rr_scheduler_if #(.DATA_W(8)) bus ();
    demux_rr_scheduler_if #(.DATA_W(8)) bus_s ();
    assign bus_s.in_valid  = bus.in_valid;
    assign bus_s.in_data   = bus.in_data;
    assign bus_s.out_ready = bus.out_ready;
    demux_rr_scheduler #(.DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode), .cfg_sel(cfg_sel), .cnt_clr(cnt_clr),
        .bus(bus.slave), .cnt0(c[0]), .cnt1(c[1]), .cnt2(c[2]), .cnt3(c[3])
    );
    demux_rr_scheduler #(.DATA_W(8), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode), .cfg_sel(cfg_sel), .cnt_clr(cnt_clr),
        .bus(bus_s.slave), .cnt0(cs[0]), .cnt1(cs[1]), .cnt2(cs[2]), .cnt3(cs[3])
    );
    always #5 clk = ~clk;
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic drive(logic v, logic [7:0] d, logic [3:0] r, logic m, logic [1:0] s, logic clr);
        bus.in_valid = v;
        bus.in_data = d;
        bus.out_ready = r;
        cfg_mode = m;
        cfg_sel = s;
        cnt_clr = clr;
    endtask
    task automatic model_reset();
        q.delete();
        rr_m = 0;
        for (int i = 0; i < 4; i++) begin
            ecnt[i] = 0;
            ecnt_s[i] = 0;
        end
    endtask
    task automatic do_reset();
        drive(0, 0, 4'hF, 0, 0, 0);
        rst_n = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask
    task automatic check_cnts();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("cnt%0d", i), c[i], ecnt[i]);
            chk($sformatf("cnt%0d_sat", i), cs[i], ecnt_s[i]);
        end
    endtask
    // one clock: compare against the scoreboard model just before the edge, then advance the model
    task automatic cycle();
        bit full, dlv;
        exp_t e, n;
        logic [3:0] exp_ov;
        #3;
        full = q.size() > 0;
        e = full ? q[0] : '{ch: 2'd0, data: 8'd0};
        dlv = full && bus.out_ready[e.ch];
        exp_ov = full ? 4'b1 << e.ch : 4'b0;
        chk("out_valid", bus.out_valid, exp_ov);
        chk("out_valid_sat", bus_s.out_valid, exp_ov);
        chk("in_ready", bus.in_ready, !full || dlv);
        if (full) begin
            chk("sel", bus.sel, e.ch);
            chk("out_data", bus.out_data, e.data);
        end
        if (dlv) begin
            void'(q.pop_front());
            ecnt[e.ch]++;
            ecnt_s[e.ch] = ecnt_s[e.ch] < 3 ? ecnt_s[e.ch] + 1 : 3;
        end
        if (cnt_clr)
            for (int i = 0; i < 4; i++) begin
                ecnt[i] = 0;
                ecnt_s[i] = 0;
            end
        if (bus.in_valid && (!full || dlv)) begin
            n.ch = cfg_mode ? cfg_sel : 2'(rr_m);
            n.data = bus.in_data;
            q.push_back(n);
            if (!cfg_mode) rr_m = (rr_m + 1) % 4;
        end
        @(posedge clk);
        @(negedge clk);
    endtask
    initial begin
        tbl = '{
            '{1'b1, 8'hA1, 4'hF, 1'b0, 2'd0, 4'h0, 8'h00, 2'd0, 1'b1},
            '{1'b1, 8'hA2, 4'hF, 1'b0, 2'd0, 4'h1, 8'hA1, 2'd0, 1'b1},
            '{1'b1, 8'hA3, 4'hF, 1'b0, 2'd0, 4'h2, 8'hA2, 2'd1, 1'b1},
            '{1'b1, 8'hA4, 4'hF, 1'b0, 2'd0, 4'h4, 8'hA3, 2'd2, 1'b1},
            '{1'b1, 8'hA5, 4'hF, 1'b0, 2'd0, 4'h8, 8'hA4, 2'd3, 1'b1},
            '{1'b0, 8'h00, 4'hF, 1'b0, 2'd0, 4'h1, 8'hA5, 2'd0, 1'b1},
            '{1'b0, 8'h00, 4'hF, 1'b0, 2'd0, 4'h0, 8'hA5, 2'd0, 1'b1},
            '{1'b1, 8'hB1, 4'hF, 1'b1, 2'd2, 4'h0, 8'hA5, 2'd0, 1'b1},
            '{1'b1, 8'hB2, 4'hF, 1'b1, 2'd2, 4'h4, 8'hB1, 2'd2, 1'b1},
            '{1'b1, 8'hB3, 4'hF, 1'b1, 2'd2, 4'h4, 8'hB2, 2'd2, 1'b1},
            '{1'b0, 8'h00, 4'hF, 1'b1, 2'd2, 4'h4, 8'hB3, 2'd2, 1'b1},
            '{1'b1, 8'hC1, 4'hF, 1'b0, 2'd2, 4'h0, 8'hB3, 2'd2, 1'b1},
            '{1'b0, 8'h00, 4'hF, 1'b0, 2'd0, 4'h2, 8'hC1, 2'd1, 1'b1},
            '{1'b0, 8'h00, 4'hF, 1'b0, 2'd0, 4'h0, 8'hC1, 2'd1, 1'b1}
        };
        do_reset();
        // RR sweep, fixed mode, then RR resumes from its untouched pointer
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].m, tbl[i].s, 1'b0);
            #1;
            chk($sformatf("vec%0d_out_valid", i), bus.out_valid, tbl[i].ov);
            chk($sformatf("vec%0d_out_data", i), bus.out_data, tbl[i].od);
            chk($sformatf("vec%0d_sel", i), bus.sel, tbl[i].osel);
            chk($sformatf("vec%0d_in_ready", i), bus.in_ready, tbl[i].ir);
            if (i == 6) begin
                chk("rr_cnt0", c[0], 2);
                chk("rr_cnt1", c[1], 1);
                chk("rr_cnt2", c[2], 1);
                chk("rr_cnt3", c[3], 1);
            end
            cycle();
        end
        chk("fixed_cnt2", c[2], 4);
        chk("fixed_cnt1", c[1], 2);
        check_cnts();
        // stall on Y1 with other channels ready
        do_reset();
        drive(1, 8'h44, 4'hF, 0, 0, 0);
        cycle();
        drive(1, 8'h55, 4'hF, 0, 0, 0);
        cycle();
        for (int i = 0; i < 5; i++) begin
            drive(1, 8'h66, 4'b1101, 0, 0, 0);
            #1;
            chk("stall_out_valid", bus.out_valid, 4'b0010);
            chk("stall_out_data", bus.out_data, 8'h55);
            chk("stall_in_ready", bus.in_ready, 1'b0);
            cycle();
        end
        drive(1, 8'h66, 4'hF, 0, 0, 0);
        #1;
        chk("unstall_in_ready", bus.in_ready, 1'b1);
        cycle();
        drive(0, 0, 4'hF, 0, 0, 0);
        #1;
        chk("after_stall_out_valid", bus.out_valid, 4'b0100);
        cycle();
        cycle();
        check_cnts();
        // config change while a word is held for Y3
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 8'hD0 + 8'(i), 4'b0111, 0, 0, 0);
            cycle();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1, 8'hE0, 4'b0111, 1, 0, 0);
            #1;
            chk("cfgchg_out_valid", bus.out_valid, 4'b1000);
            chk("cfgchg_sel", bus.sel, 2'd3);
            cycle();
        end
        drive(1, 8'hE0, 4'hF, 1, 0, 0);
        cycle();
        drive(0, 0, 4'hF, 1, 0, 0);
        #1;
        chk("cfgchg_next_out_valid", bus.out_valid, 4'b0001);
        chk("cfgchg_next_data", bus.out_data, 8'hE0);
        cycle();
        cycle();
        check_cnts();
        // saturation on the narrow-counter instance and clear beating a delivery
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 8'h10 + 8'(i), 4'hF, 1, 0, 0);
            cycle();
        end
        drive(0, 0, 4'hF, 1, 0, 0);
        cycle();
        chk("sat_cnt0", cs[0], 3);
        chk("wide_cnt0", c[0], 5);
        check_cnts();
        drive(1, 8'h20, 4'hF, 1, 0, 0);
        cycle();
        drive(0, 0, 4'hF, 1, 0, 1);
        cycle();
        drive(0, 0, 4'hF, 1, 0, 0);
        #1;
        chk("clr_cnt0", c[0], 0);
        chk("clr_cnt0_sat", cs[0], 0);
        cycle();
        check_cnts();
        // async reset while holding a word
        drive(1, 8'h30, 4'hF, 0, 0, 0);
        cycle();
        drive(1, 8'h31, 4'hF, 0, 0, 0);
        cycle();
        drive(1, 8'h32, 4'h0, 0, 0, 0);
        #1;
        chk("prerst_out_valid", bus.out_valid, 4'b0010);
        chk("prerst_cnt0", c[0], 1);
        #1;
        rst_n = 0;
        #1;
        chk("rst_out_valid", bus.out_valid, 4'b0000);
        chk("rst_sel", bus.sel, 2'd0);
        chk("rst_out_data", bus.out_data, 8'h00);
        chk("rst_cnt0", c[0], 0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        drive(1, 8'h40, 4'hF, 0, 0, 0);
        cycle();
        drive(0, 0, 4'hF, 0, 0, 0);
        #1;
        chk("postrst_out_valid", bus.out_valid, 4'b0001);
        chk("postrst_out_data", bus.out_data, 8'h40);
        cycle();
        cycle();
        check_cnts();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/demux_rr_scheduler.md
Name: demux_rr_scheduler

Overview:
- Sequencer for the 1:4 demultiplexer datapath. Accepts a single valid/ready input stream and steers each word to exactly one of four output channels.
- Channel is chosen by round-robin rotation or by a fixed software-selected channel.
- Provides the registered 2-bit select and one-hot channel valids that drive the demux, plus per-channel delivery counters for status.

Parameters:
- DATA_W, 8, width of the data word carried through the demux.
- CNT_W, 16, width of each per-channel delivered-word counter (saturating).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cfg_mode  input  1  0 = round-robin, 1 = fixed channel.
- cfg_sel  input  2  target channel in fixed mode (S1 = bit1, S0 = bit0).
- cnt_clr  input  1  synchronous clear of all delivery counters.
- in_valid  input  1  upstream word available.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  DATA_W  upstream word.
- sel  output  2  registered select to demux (Y0..Y3 = 00..11).
- out_valid  output  4  one-hot channel valid, bit i = channel Yi.
- out_ready  input  4  per-channel downstream ready.
- out_data  output  DATA_W  held word, valid only on the channel flagged in out_valid.
- cnt0, cnt1, cnt2, cnt3  output  CNT_W each  words delivered per channel.

Behaviour:
- Reset (async assert, sync release) sets: holding register empty, out_valid = 0000, sel = 00, out_data = 0, rr_ptr = 0, all counters = 0. in_ready = 1 in the first cycle after release.
- Single-entry holding register with FSM states EMPTY and FULL.
  - EMPTY: in_ready = 1. On in_valid, latch in_data, latch target channel into sel, go to FULL.
  - FULL: out_valid = onehot(sel). out_data = held word.
  - Delivery occurs when out_ready[sel] = 1.
  - in_ready = deliver, so a new word is accepted in the same cycle the held word leaves. This gives back-to-back throughput of 1 word/cycle.
  - Delivery without a new accept returns to EMPTY. Delivery with an accept stays FULL.
- Latency: in_data accepted at cycle N appears on out_data/out_valid at cycle N+1.
- Target selection at accept:
  - cfg_mode = 0: target = rr_ptr, then rr_ptr <= rr_ptr + 1 mod 4 (3 wraps to 0).
  - cfg_mode = 1: target = cfg_sel. rr_ptr is unchanged.
- cfg_mode/cfg_sel changes affect only subsequent accepts. A held word keeps its latched sel.
- Round-robin is strict order. A stalled target channel blocks the stream; there is no skipping. out_ready on non-selected channels is ignored.
- out_valid is never multi-hot. While FULL, out_valid, sel and out_data are stable until delivery.
- Counters:
  - cnt[sel] increments by 1 on each delivery.
  - Counters saturate at 2^CNT_W - 1.
  - cnt_clr zeroes all counters and takes priority over a same-cycle increment; that word is not counted.
- Reset asserted mid-transfer discards the held word immediately; no out_valid is produced afterward.

Decomposition:
- Shared package: channel-count constant (4), select encodings CH_Y0..CH_Y3 = 2'd0..2'd3, mode constants MODE_RR = 0 and MODE_FIXED = 1, FSM state typedef {EMPTY, FULL}.
- One natural sub-module: sat_counter (CNT_W, inc, clr). Instantiated four times.
- The demux decode (onehot from sel) stays inline.

Test Plan:
- RR sweep: mode 0, all out_ready = 1, send 0xA1,0xA2,0xA3,0xA4,0xA5 back-to-back.
  - Delivered on Y0,Y1,Y2,Y3,Y0 at one word/cycle.
  - Each 1-cycle latency; in_ready stays 1.
  - cnt0 = 2, cnt1 = cnt2 = cnt3 = 1.
- Fixed mode: mode 1, cfg_sel = 10, send 3 words.
  - All appear with out_valid = 0100 and sel = 10.
  - cnt2 = 3; rr_ptr unchanged (next RR word goes to its prior pointer).
- Stall: RR, out_ready[1] = 0 for 5 cycles, second word 0x55 targets Y1.
  - out_valid = 0010 and out_data = 0x55 held stable; in_ready = 0 for 5 cycles.
  - Ready on Y0/Y2/Y3 is ignored.
  - Delivers on the cycle out_ready[1] rises.
- Config change while FULL: word held for Y3, switch to mode 1 with cfg_sel = 00.
  - Held word still delivered on Y3.
  - Next word goes to Y0.
- Counter saturation/clear: CNT_W = 2 override, send 5 words fixed to Y0.
  - cnt0 = 3 (saturated).
  - cnt_clr coincident with a delivery leaves cnt0 = 0.
- Async reset mid-operation: assert rst_n = 0 mid-clock while FULL.
  - out_valid = 0000, sel = 00, counters = 0 immediately, without a clock edge.
  - After release, first RR word goes to Y0.
